// File: rtl/lvds_rx_frame_align.sv
// Core-domain word aligner for the x6 LVDS ADC receive path.
// Watches the deserialized frame-clock lane, pulses bitslip until the frame word
// matches the expected pattern, then forwards the lane words with a valid flag.
// Acquisition is gated by a synchronized PLL lock and restarts whenever lock or
// alignment is lost.
module lvds_rx_frame_align #(
    parameter int               LANES         = 4,
    parameter int               WIDTH         = 6,
    parameter logic [WIDTH-1:0] FRAME_PATTERN = 6'b111000,
    parameter int               SETTLE_CYCLES = 16,
    parameter int               SLIP_WAIT     = 4,
    parameter int               MATCH_COUNT   = 8,
    parameter int               LOSS_COUNT    = 4,
    parameter int               MAX_SLIPS     = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pll_locked,
    input  logic [WIDTH-1:0]         frame_word,
    input  logic [LANES*WIDTH-1:0]   data_in,
    output logic                     bitslip,
    output logic                     aligned,
    output logic                     align_fail,
    output logic [LANES*WIDTH-1:0]   data_out,
    output logic                     data_valid,
    output logic [15:0]              frame_err_count
);

    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
    localparam int MATCH_W = $clog2(MATCH_COUNT + 1);
    localparam int LOSS_W  = $clog2(LOSS_COUNT + 1);
    localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);

    localparam logic [SET_W-1:0]   SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LOAD   = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST   = LOSS_W'(LOSS_COUNT - 1);
    localparam logic [SLIP_W-1:0]  SLIP_MAX    = SLIP_W'(MAX_SLIPS);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_CHECK     = 3'd2,
        ST_SLIP      = 3'd3,
        ST_SLIP_WAIT = 3'd4,
        ST_ALIGNED   = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    state_t               state_r, state_s;
    logic                 lock_meta_r, lock_sync_r, lock_s;
    logic                 frame_match_s;
    logic [SET_W-1:0]     settle_cnt_r, settle_cnt_s;
    logic [WAIT_W-1:0]    wait_cnt_r, wait_cnt_s;
    logic [MATCH_W-1:0]   match_cnt_r, match_cnt_s;
    logic [LOSS_W-1:0]    loss_cnt_r, loss_cnt_s;
    logic [SLIP_W-1:0]    slip_cnt_r, slip_cnt_s;
    logic [15:0]          err_cnt_s;

    // Saturating 16-bit increment for the frame error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    assign lock_s        = lock_sync_r;
    assign frame_match_s = (frame_word == FRAME_PATTERN);

    // Two-flop synchronizer bringing PLL lock into the core domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_WAIT_LOCK;
            settle_cnt_r <= SET_W'(0);
            wait_cnt_r   <= WAIT_W'(0);
            match_cnt_r  <= MATCH_W'(0);
            loss_cnt_r   <= LOSS_W'(0);
            slip_cnt_r   <= SLIP_W'(0);
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
            wait_cnt_r   <= wait_cnt_s;
            match_cnt_r  <= match_cnt_s;
            loss_cnt_r   <= loss_cnt_s;
            slip_cnt_r   <= slip_cnt_s;
        end
    end

    // Next-state and counter update; loss of lock overrides every transition.
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        wait_cnt_s   = wait_cnt_r;
        match_cnt_s  = match_cnt_r;
        loss_cnt_s   = loss_cnt_r;
        slip_cnt_s   = slip_cnt_r;
        err_cnt_s    = frame_err_count;
        if (!lock_s) begin
            state_s     = ST_WAIT_LOCK;
            slip_cnt_s  = SLIP_W'(0);
            match_cnt_s = MATCH_W'(0);
            loss_cnt_s  = LOSS_W'(0);
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    state_s      = ST_SETTLE;
                    settle_cnt_s = SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SET_W'(0)) begin
                        state_s     = ST_CHECK;
                        match_cnt_s = MATCH_W'(0);
                    end else begin
                        settle_cnt_s = settle_cnt_r - SET_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (frame_match_s) begin
                        if (match_cnt_r == MATCH_LAST) begin
                            state_s     = ST_ALIGNED;
                            match_cnt_s = MATCH_W'(0);
                            loss_cnt_s  = LOSS_W'(0);
                        end else begin
                            match_cnt_s = match_cnt_r + MATCH_W'(1);
                        end
                    end else begin
                        match_cnt_s = MATCH_W'(0);
                        if (slip_cnt_r == SLIP_MAX) begin
                            state_s = ST_FAIL;
                        end else begin
                            state_s = ST_SLIP;
                        end
                    end
                end
                ST_SLIP: begin
                    slip_cnt_s = slip_cnt_r + SLIP_W'(1);
                    state_s    = ST_SLIP_WAIT;
                    wait_cnt_s = WAIT_LOAD;
                end
                ST_SLIP_WAIT: begin
                    if (wait_cnt_r == WAIT_W'(0)) begin
                        state_s     = ST_CHECK;
                        match_cnt_s = MATCH_W'(0);
                    end else begin
                        wait_cnt_s = wait_cnt_r - WAIT_W'(1);
                    end
                end
                ST_ALIGNED: begin
                    if (frame_match_s) begin
                        loss_cnt_s = LOSS_W'(0);
                    end else begin
                        err_cnt_s = sat_inc16(frame_err_count);
                        if (loss_cnt_r == LOSS_LAST) begin
                            state_s     = ST_CHECK;
                            slip_cnt_s  = SLIP_W'(0);
                            loss_cnt_s  = LOSS_W'(0);
                            match_cnt_s = MATCH_W'(0);
                        end else begin
                            loss_cnt_s = loss_cnt_r + LOSS_W'(1);
                        end
                    end
                end
                ST_FAIL: begin
                    state_s = ST_FAIL;
                end
                default: begin
                    state_s = ST_WAIT_LOCK;
                end
            endcase
        end
    end

    // Registered outputs decoded from the state being entered, so flags change on
    // the same edge as the state; data_out only loads while entering/staying aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitslip         <= 1'b0;
            aligned         <= 1'b0;
            data_valid      <= 1'b0;
            align_fail      <= 1'b0;
            data_out        <= '0;
            frame_err_count <= 16'd0;
        end else begin
            bitslip         <= (state_s == ST_SLIP);
            aligned         <= (state_s == ST_ALIGNED);
            data_valid      <= (state_s == ST_ALIGNED);
            align_fail      <= (state_s == ST_FAIL);
            frame_err_count <= err_cnt_s;
            if (state_s == ST_ALIGNED) begin
                data_out <= data_in;
            end else begin
                data_out <= data_out;
            end
        end
    end

endmodule

// File: tb/tb_lvds_rx_frame_align.sv
// Self-checking bench for lvds_rx_frame_align. A behavioural deserializer model
// rotates the frame lane one bit per bitslip pulse; expected event times come
// from the acquisition timing rules computed arithmetically.
module tb_lvds_rx_frame_align;

    localparam int               LANES = 4;
    localparam int               WIDTH = 6;
    localparam logic [WIDTH-1:0] PAT   = 6'b111000;
    localparam int               SETTLE = 16;
    localparam int               SWAIT  = 4;
    localparam int               MATCHN = 8;
    localparam int               LOSSN  = 4;
    localparam int               MAXS   = 12;

    logic                   clk;
    logic                   rst_n;
    logic                   pll_locked;
    logic [WIDTH-1:0]       frame_word;
    logic [LANES*WIDTH-1:0] data_in;
    logic                   bitslip;
    logic                   aligned;
    logic                   align_fail;
    logic [LANES*WIDTH-1:0] data_out;
    logic                   data_valid;
    logic [15:0]            frame_err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int offset   = 0;
    bit fixed_mode = 1'b0;
    logic [WIDTH-1:0] fixed_word = 6'b000000;
    bit prev_slip = 1'b0;
    int consec_err = 0;
    int exp_err = 0;
    int slip_times[$];

    lvds_rx_frame_align #(
        .LANES(LANES), .WIDTH(WIDTH), .FRAME_PATTERN(PAT),
        .SETTLE_CYCLES(SETTLE), .SLIP_WAIT(SWAIT), .MATCH_COUNT(MATCHN),
        .LOSS_COUNT(LOSSN), .MAX_SLIPS(MAXS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
        .frame_word(frame_word), .data_in(data_in),
        .bitslip(bitslip), .aligned(aligned), .align_fail(align_fail),
        .data_out(data_out), .data_valid(data_valid),
        .frame_err_count(frame_err_count)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rol(input logic [WIDTH-1:0] v, input int r);
        logic [WIDTH-1:0] t;
        t = v;
        for (int i = 0; i < r; i++) t = {t[WIDTH-2:0], t[WIDTH-1]};
        return t;
    endfunction

    task automatic drive_frame();
        frame_word = fixed_mode ? fixed_word : rol(PAT, offset);
    endtask

    // One clock: sample 1 time unit after the edge, then let the deserializer
    // model react to a bitslip pulse.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bitslip) begin
            slip_times.push_back(cyc);
            if (prev_slip) consec_err++;
            offset = (offset + WIDTH - 1) % WIDTH;
        end
        prev_slip = bitslip;
        drive_frame();
    endtask

    // Lock from WAIT_LOCK and run to alignment (or failure when never_match).
    task automatic acquire(input int k, input bit never_match, input string tag);
        int t0, align_c, fail_c, base;
        slip_times.delete();
        consec_err = 0;
        offset = k;
        fixed_mode = never_match;
        fixed_word = PAT ^ WIDTH'($urandom_range(1, 63));
        drive_frame();
        pll_locked = 1'b1;
        t0 = cyc + 1;
        align_c = -1;
        fail_c = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (aligned && align_c < 0) align_c = cyc;
            if (align_fail && fail_c < 0) fail_c = cyc;
            if (!never_match && align_c >= 0) break;
            if (never_match && fail_c >= 0 && cyc >= fail_c + 10) break;
        end
        base = t0 + 2 + SETTLE;
        check({tag, "_no_consec_slip"}, 32'(consec_err), 32'd0);
        if (!never_match) begin
            check({tag, "_align_cycle"}, 32'(align_c), 32'(base + k * (SWAIT + 2) + MATCHN));
            check({tag, "_slip_count"}, 32'(slip_times.size()), 32'(k));
            check({tag, "_valid"}, 32'(data_valid), 32'd1);
            check({tag, "_no_fail"}, 32'(align_fail), 32'd0);
            if (k > 0) check({tag, "_first_slip"}, 32'(slip_times[0]), 32'(base + 1));
            for (int i = 1; i < slip_times.size(); i++)
                check({tag, "_slip_spacing"}, 32'(slip_times[i] - slip_times[i-1]), 32'(SWAIT + 2));
        end else begin
            check({tag, "_fail_cycle"}, 32'(fail_c), 32'(base + MAXS * (SWAIT + 2) + 1));
            check({tag, "_slip_count"}, 32'(slip_times.size()), 32'(MAXS));
            check({tag, "_not_aligned"}, 32'(aligned), 32'd0);
            check({tag, "_fail_held"}, 32'(align_fail), 32'd1);
        end
    endtask

    task automatic unlock(input string tag);
        pll_locked = 1'b0;
        repeat (4) step();
        check({tag, "_unlock_fail"}, 32'(align_fail), 32'd0);
        check({tag, "_unlock_aligned"}, 32'(aligned), 32'd0);
        check({tag, "_unlock_valid"}, 32'(data_valid), 32'd0);
    endtask

    initial begin
        logic [LANES*WIDTH-1:0] v, last;
        int n0;
        rst_n = 1'b0;
        pll_locked = 1'b0;
        data_in = '0;
        fixed_mode = 1'b0;
        offset = 0;
        drive_frame();
        #3;
        check("rst_bitslip", 32'(bitslip), 32'd0);
        check("rst_aligned", 32'(aligned), 32'd0);
        check("rst_fail", 32'(align_fail), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_errcnt", 32'(frame_err_count), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();

        // Already aligned frame lane
        acquire(0, 1'b0, "t1");

        // Data forwarding while aligned
        for (int i = 0; i < 7; i++) begin
            v = (i == 0) ? 24'h5A5A5A : LANES*WIDTH'($urandom);
            data_in = v;
            step();
            check("t5_data", 32'(data_out), 32'(v));
            check("t5_valid", 32'(data_valid), 32'd1);
        end

        // Tolerated mismatches, then loss of alignment
        fixed_mode = 1'b1;
        fixed_word = ~PAT;
        drive_frame();
        repeat (3) step();
        exp_err += 3;
        fixed_mode = 1'b0;
        drive_frame();
        step();
        check("t4_still_aligned", 32'(aligned), 32'd1);
        check("t4_err3", 32'(frame_err_count), 32'(exp_err));
        fixed_mode = 1'b1;
        drive_frame();
        repeat (3) step();
        check("t4_aligned_3rd", 32'(aligned), 32'd1);
        step();
        exp_err += 4;
        check("t4_lost_aligned", 32'(aligned), 32'd0);
        check("t4_lost_valid", 32'(data_valid), 32'd0);
        check("t4_err7", 32'(frame_err_count), 32'(exp_err));
        step();
        check("t4_reacq_slip", 32'(bitslip), 32'd1);
        unlock("t4");
        check("t4_err_kept", 32'(frame_err_count), 32'(exp_err));

        // Two-bit rotation needs exactly two slips
        acquire(2, 1'b0, "t2");
        // data_out holds after valid drops
        last = data_in;
        pll_locked = 1'b0;
        repeat (4) step();
        data_in = ~last;
        repeat (2) step();
        check("hold_data", 32'(data_out), 32'(last));
        check("hold_valid", 32'(data_valid), 32'd0);

        // Never matching frame lane
        acquire(0, 1'b1, "t3");
        unlock("t3");
        // Slip budget starts over after re-lock
        acquire(5, 1'b0, "t3_relock");
        unlock("t3_relock");

        // Random rotations
        for (int r = 0; r < 4; r++) begin
            acquire($urandom_range(0, WIDTH - 1), 1'b0, "rnd");
            unlock("rnd");
        end

        // Lock drop during SLIP_WAIT
        fixed_mode = 1'b0;
        offset = 3;
        drive_frame();
        pll_locked = 1'b1;
        n0 = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bitslip) begin
                n0 = 1;
                break;
            end
        end
        check("t6_first_slip_seen", 32'(n0), 32'd1);
        step();
        step();
        pll_locked = 1'b0;
        n0 = slip_times.size();
        repeat (12) step();
        check("t6_no_slip_after_drop", 32'(slip_times.size() - n0), 32'd0);
        check("t6_drop_aligned", 32'(aligned), 32'd0);
        check("t6_drop_bitslip", 32'(bitslip), 32'd0);
        acquire(2, 1'b0, "t6_relock");

        // Asynchronous reset while aligned
        rst_n = 1'b0;
        #1;
        exp_err = 0;
        check("t6_rst_aligned", 32'(aligned), 32'd0);
        check("t6_rst_valid", 32'(data_valid), 32'd0);
        check("t6_rst_data", 32'(data_out), 32'd0);
        check("t6_rst_err", 32'(frame_err_count), 32'(exp_err));
        check("t6_rst_bitslip", 32'(bitslip), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        acquire(1, 1'b0, "t6_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
